// File: rtl/rank_cmd_arbiter.sv
// rank_cmd_arbiter: multi-rank command-bus arbiter for one DDR channel.
// Grants at most one command per cycle. CAS spacing covers tCCD_S, tCCD_L
// and the rank-switch penalty. Selection is round-robin, and aged ranks
// take priority so that no rank starves.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-low reset
//   req_valid    per-rank request pending
//   req_cas      per-rank request is CAS (RD/WR); 0 = ACT/PRE/REF
//   req_bg       per-rank bank group, slice [r*BGW +: BGW]
//   grant        one-hot grant (combinational)
//   grant_valid  OR of grant (combinational)
//   grant_rank   granted rank index, 0 when idle (combinational)
//   grant_cas    granted command is CAS (combinational)
//   aged_mask    registered, rank age counter has reached AGE_LIMIT
module rank_cmd_arbiter #(
    parameter int unsigned NUM_RANKS = 4,
    parameter int unsigned BGW       = 2,
    parameter int unsigned TCCD_S    = 4,
    parameter int unsigned TCCD_L    = 6,
    parameter int unsigned TRTRS     = 1,
    parameter int unsigned AGE_LIMIT = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_RANKS-1:0]          req_valid,
    input  logic [NUM_RANKS-1:0]          req_cas,
    input  logic [NUM_RANKS*BGW-1:0]      req_bg,
    output logic [NUM_RANKS-1:0]          grant,
    output logic                          grant_valid,
    output logic [$clog2(NUM_RANKS)-1:0]  grant_rank,
    output logic                          grant_cas,
    output logic [NUM_RANKS-1:0]          aged_mask
);

    localparam int unsigned RANK_W      = $clog2(NUM_RANKS);
    localparam int unsigned ELAPSED_MAX = TCCD_S + TRTRS + TCCD_L;
    localparam int unsigned ELAPSED_W   = $clog2(ELAPSED_MAX + 1);
    localparam int unsigned AGE_W       = $clog2(AGE_LIMIT + 1);

    // Registered arbitration state
    logic [RANK_W-1:0]    rrPtr;
    logic [ELAPSED_W-1:0] elapsed;
    logic [RANK_W-1:0]    lastRank;
    logic [BGW-1:0]       lastBg;
    logic                 casSeen;
    logic [AGE_W-1:0]     age [NUM_RANKS];
    logic [NUM_RANKS-1:0] agedMask;

    // Combinational arbitration signals
    logic [NUM_RANKS-1:0] casOk;
    logic [NUM_RANKS-1:0] eligible;
    logic [NUM_RANKS-1:0] selSet;
    logic                 blockCas;
    logic                 selFound;
    logic [RANK_W-1:0]    selRank;
    logic [NUM_RANKS-1:0] grantRaw;
    logic                 selCas;
    logic [BGW-1:0]       selBg;
    int unsigned          scanIdx;
    logic [RANK_W-1:0]    nextPtr;
    logic [AGE_W-1:0]     ageNext [NUM_RANKS];

    // Required CAS-to-CAS gap for a candidate relative to the last CAS
    function automatic logic [ELAPSED_W-1:0] gapOf(input logic sameRank, input logic sameBg);
        if (sameRank && sameBg) begin
            return ELAPSED_W'(TCCD_L);
        end else if (sameRank) begin
            return ELAPSED_W'(TCCD_S);
        end else begin
            return ELAPSED_W'(TCCD_S + TRTRS);
        end
    endfunction

    // Spacing check, aged-rank CAS blocking and eligibility
    always_comb begin
        casOk    = '0;
        eligible = '0;
        for (int r = 0; r < NUM_RANKS; r++) begin
            casOk[r] = !casSeen ||
                       (elapsed >= gapOf(RANK_W'(r) == lastRank,
                                         req_bg[r*BGW +: BGW] == lastBg));
        end
        // An aged rank stuck on spacing freezes CAS traffic from younger ranks
        // so the spacing window can open for it.
        blockCas = |(agedMask & req_valid & req_cas & ~casOk);
        for (int r = 0; r < NUM_RANKS; r++) begin
            eligible[r] = req_valid[r] &
                          (~req_cas[r] | (casOk[r] & (~blockCas | agedMask[r])));
        end
        selSet = (|(eligible & agedMask)) ? (eligible & agedMask) : eligible;
    end

    // Rotating priority scan starting at rrPtr
    always_comb begin
        selFound = 1'b0;
        selRank  = '0;
        scanIdx  = 0;
        for (int i = 0; i < NUM_RANKS; i++) begin
            scanIdx = 32'(rrPtr) + 32'(i);
            if (scanIdx >= NUM_RANKS) begin
                scanIdx = scanIdx - NUM_RANKS;
            end
            if (!selFound && selSet[RANK_W'(scanIdx)]) begin
                selFound = 1'b1;
                selRank  = RANK_W'(scanIdx);
            end
        end
    end

    // One-hot grant plus the granted command's attributes
    always_comb begin
        grantRaw = '0;
        selCas   = 1'b0;
        selBg    = '0;
        for (int r = 0; r < NUM_RANKS; r++) begin
            if (selFound && (selRank == RANK_W'(r))) begin
                grantRaw[r] = 1'b1;
                selCas      = req_cas[r];
                selBg       = req_bg[r*BGW +: BGW];
            end
        end
        nextPtr = (32'(selRank) == NUM_RANKS - 1) ? '0 : selRank + RANK_W'(1);
    end

    // Per-rank age: cleared when idle or granted, otherwise saturating count
    always_comb begin
        for (int r = 0; r < NUM_RANKS; r++) begin
            ageNext[r] = age[r];
            if (grantRaw[r] || !req_valid[r]) begin
                ageNext[r] = '0;
            end else if (age[r] != AGE_W'(AGE_LIMIT)) begin
                ageNext[r] = age[r] + AGE_W'(1);
            end
        end
    end

    // Grants are forced low while reset is held
    assign grant       = rst ? grantRaw : '0;
    assign grant_valid = rst & selFound;
    assign grant_rank  = (rst & selFound) ? selRank : '0;
    assign grant_cas   = rst & selFound & selCas;
    assign aged_mask   = agedMask;

    // Arbitration state update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rrPtr    <= '0;
            elapsed  <= ELAPSED_W'(ELAPSED_MAX);
            lastRank <= '0;
            lastBg   <= '0;
            casSeen  <= 1'b0;
            agedMask <= '0;
            for (int r = 0; r < NUM_RANKS; r++) begin
                age[r] <= '0;
            end
        end else begin
            if (selFound) begin
                rrPtr <= nextPtr;
            end
            if (selFound && selCas) begin
                elapsed  <= ELAPSED_W'(1);
                lastRank <= selRank;
                lastBg   <= selBg;
                casSeen  <= 1'b1;
            end else if (elapsed != ELAPSED_W'(ELAPSED_MAX)) begin
                elapsed <= elapsed + ELAPSED_W'(1);
            end
            for (int r = 0; r < NUM_RANKS; r++) begin
                age[r]      <= ageNext[r];
                agedMask[r] <= (ageNext[r] == AGE_W'(AGE_LIMIT));
            end
        end
    end

endmodule

// File: tb/tb_rank_cmd_arbiter.sv
// Testbench for rank_cmd_arbiter: directed scenarios plus randomized traffic,
// scored against a timestamp-based reference model.
module tb_rank_cmd_arbiter;

    localparam int N   = 4;
    localparam int BGW = 2;
    localparam int TS  = 4;
    localparam int TL  = 6;
    localparam int TR  = 1;
    localparam int AL  = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_cas = '0;
    logic [N*BGW-1:0]  req_bg = '0;
    logic [N-1:0]      grant;
    logic              grant_valid;
    logic [1:0]        grant_rank;
    logic              grant_cas;
    logic [N-1:0]      aged_mask;

    rank_cmd_arbiter #(
        .NUM_RANKS(N), .BGW(BGW), .TCCD_S(TS), .TCCD_L(TL), .TRTRS(TR), .AGE_LIMIT(AL)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_cas(req_cas), .req_bg(req_bg),
        .grant(grant), .grant_valid(grant_valid), .grant_rank(grant_rank),
        .grant_cas(grant_cas), .aged_mask(aged_mask)
    );

    always #5 clk = ~clk;

    // Expected response for one cycle; d* fields are optional hand-computed checks
    typedef struct {
        int grant;
        int rank;
        int cas;
        int aged;
        int dRank;   // -2 = unchecked, -1 = no grant
        int dCas;    // -1 = unchecked
        int dAged;   // -1 = unchecked
    } exp_t;

    exp_t sbq[$];
    exp_t me;
    int checks = 0;
    int errors = 0;

    // Reference model: CAS history kept as absolute cycle stamps
    int mCycle = 0;
    int mLastCas = 0;
    int mLastRank = 0;
    int mLastBg = 0;
    bit mCasSeen = 0;
    int mRr = 0;
    int mAge [N] = '{default: 0};

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, got, want);
        end
    endtask

    // Monitor: compares every presented cycle against the scoreboard
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            me = sbq.pop_front();
            chk("grant", int'(grant), me.grant);
            chk("grant_valid", int'(grant_valid), (me.grant != 0) ? 1 : 0);
            chk("grant_rank", int'(grant_rank), me.rank);
            chk("grant_cas", int'(grant_cas), me.cas);
            chk("aged_mask", int'(aged_mask), me.aged);
            if (me.dRank != -2) chk("dir_rank", grant_valid ? int'(grant_rank) : -1, me.dRank);
            if (me.dCas >= 0)   chk("dir_cas", int'(grant_cas), me.dCas);
            if (me.dAged >= 0)  chk("dir_aged", int'(aged_mask), me.dAged);
        end
    end

    // Drive one cycle, predict it, push the prediction, advance the model
    task automatic step(input logic rv, input logic [N-1:0] v, input logic [N-1:0] c,
                        input logic [N*BGW-1:0] b, input int dRank, input int dCas,
                        input int dAged, output int mg);
        exp_t e;
        bit [N-1:0] ag, ok, el, sel;
        bit blk;
        int gap, bgr;
        rst = rv; req_valid = v; req_cas = c; req_bg = b;
        for (int r = 0; r < N; r++) begin
            ag[r] = (mAge[r] >= AL);
            bgr = int'(b[r*BGW +: BGW]);
            if (r == mLastRank) gap = (bgr == mLastBg) ? TL : TS;
            else gap = TS + TR;
            ok[r] = !mCasSeen || ((mCycle - mLastCas) >= gap);
        end
        blk = |(ag & v & c & ~ok);
        for (int r = 0; r < N; r++) begin
            el[r] = v[r] && (!c[r] || (ok[r] && (!blk || ag[r])));
        end
        sel = (|(el & ag)) ? (el & ag) : el;
        mg = -1;
        for (int i = 0; i < N; i++) begin
            if (mg < 0 && sel[(mRr + i) % N]) mg = (mRr + i) % N;
        end
        if (!rv) mg = -1;
        e.grant = (mg >= 0) ? (1 << mg) : 0;
        e.rank  = (mg >= 0) ? mg : 0;
        e.cas   = (mg >= 0) ? int'(c[mg]) : 0;
        e.aged  = rv ? int'(ag) : 0;
        e.dRank = dRank; e.dCas = dCas; e.dAged = dAged;
        sbq.push_back(e);
        if (!rv) begin
            mRr = 0; mCasSeen = 0; mLastRank = 0; mLastBg = 0;
            for (int r = 0; r < N; r++) mAge[r] = 0;
        end else begin
            if (mg >= 0) begin
                mRr = (mg + 1) % N;
                if (c[mg]) begin
                    mCasSeen = 1; mLastCas = mCycle; mLastRank = mg;
                    mLastBg = int'(b[mg*BGW +: BGW]);
                end
            end
            for (int r = 0; r < N; r++) begin
                if (mg == r || !v[r]) mAge[r] = 0;
                else if (mAge[r] < AL) mAge[r]++;
            end
        end
        mCycle++;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] oneHot(input int r);
        logic [N-1:0] x;
        x = '0;
        x[r] = 1'b1;
        return x;
    endfunction

    function automatic logic [N*BGW-1:0] bgAt(input int r, input int bg);
        logic [N*BGW-1:0] x;
        x = '0;
        x[r*BGW +: BGW] = BGW'(bg);
        return x;
    endfunction

    task automatic resetCycle();
        int mg;
        step(1'b0, '0, '0, '0, -1, 0, 0, mg);
    endtask

    // CAS on ra/ba, then CAS on rb/bb must wait exactly gap cycles
    task automatic spacing(input int ra, input int ba, input int rb, input int bb, input int gap);
        int mg;
        resetCycle();
        step(1'b1, oneHot(ra), oneHot(ra), bgAt(ra, ba), ra, 1, -1, mg);
        for (int k = 1; k <= gap; k++) begin
            step(1'b1, oneHot(rb), oneHot(rb), bgAt(rb, bb),
                 (k == gap) ? rb : -1, (k == gap) ? 1 : 0, -1, mg);
        end
        step(1'b1, '0, '0, '0, -1, 0, -1, mg);
    endtask

    initial begin
        int mg;
        logic [N-1:0] pv, pc;
        logic [N*BGW-1:0] pb;
        logic [N*BGW-1:0] sb;
        logic rv;
        int dens, casPct, er;

        @(posedge clk);
        #1;

        // Reset held with all requests high, then round-robin on non-CAS
        step(1'b0, 4'hF, 4'h0, '0, -1, 0, 0, mg);
        step(1'b0, 4'hF, 4'hF, '0, -1, 0, 0, mg);
        for (int k = 0; k < 5; k++) step(1'b1, 4'hF, 4'h0, '0, k % 4, 0, -1, mg);

        // CAS spacing: same bg, different bg, rank switch
        spacing(1, 0, 1, 0, 6);
        spacing(1, 0, 1, 1, 4);
        spacing(1, 0, 2, 0, 5);

        // Non-CAS slips into a CAS spacing window without disturbing it
        resetCycle();
        step(1'b1, 4'b0001, 4'b0001, '0, 0, 1, -1, mg);
        step(1'b1, 4'b0001, 4'b0001, '0, -1, 0, -1, mg);
        step(1'b1, 4'b1001, 4'b0001, '0, 3, 0, -1, mg);
        for (int k = 3; k <= 5; k++) step(1'b1, 4'b0001, 4'b0001, '0, -1, 0, -1, mg);
        step(1'b1, 4'b0001, 4'b0001, '0, 0, 1, -1, mg);

        // Starvation: rank 0 alternates bg (gap 4), rank 2 needs gap 5
        resetCycle();
        for (int c = 0; c <= 18; c++) begin
            sb = '0;
            sb[1:0] = (c >= 13) ? 2'd0 : 2'(((c + 3) / 4) % 2);
            er = (c == 17) ? 2 : ((c % 4 == 0 && c <= 12) ? 0 : -1);
            step(1'b1, (c <= 17) ? 4'b0101 : 4'b0001, 4'b0101, sb,
                 er, (er >= 0) ? 1 : 0, (c >= 15 && c <= 17) ? 4 : 0, mg);
        end

        // Async reset right after a CAS grant; next CAS is unconstrained
        resetCycle();
        step(1'b1, 4'b1000, 4'b1000, bgAt(3, 2), 3, 1, -1, mg);
        step(1'b0, 4'b1000, 4'b1000, bgAt(3, 2), -1, 0, 0, mg);
        step(1'b1, 4'b1000, 4'b1000, bgAt(3, 2), 3, 1, -1, mg);
        step(1'b1, 4'b0010, 4'b0010, bgAt(1, 2), -1, 0, -1, mg);

        // Randomized traffic honouring the hold-until-granted handshake
        pv = '0; pc = '0; pb = '0;
        for (int blkI = 0; blkI < 4; blkI++) begin
            dens   = (blkI == 0) ? 30 : (blkI == 1) ? 60 : 100;
            casPct = (blkI == 3) ? 100 : 60;
            for (int k = 0; k < 400; k++) begin
                for (int r = 0; r < N; r++) begin
                    if (!pv[r] && ($urandom_range(99) < 32'(dens))) begin
                        pv[r] = 1'b1;
                        pc[r] = ($urandom_range(99) < 32'(casPct));
                        pb[r*BGW +: BGW] = BGW'($urandom_range(3));
                    end
                end
                rv = ($urandom_range(299) != 0);
                step(rv, pv, pc, pb, -2, -1, -1, mg);
                if (mg >= 0) pv[mg] = 1'b0;
            end
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rank_cmd_arbiter.md
# rank_cmd_arbiter

Parametrised multi-rank command-bus arbiter for the Memory Controller Backend, one instance per channel. It sits between the per-rank controllers and the shared DDR CMD/address bus and grants at most one command per cycle. It enforces CAS-to-CAS spacing across ranks and bank groups, including tCCD_S, tCCD_L and the rank-switch penalty. Round-robin fairness is combined with age-based starvation protection.

## Interface
Parameters:
- NUM_RANKS, 4, number of requesting ranks (≥2)
- BGW, 2, bank-group field width per request
- TCCD_S, 4, CAS-to-CAS cycles, same rank, different bank group
- TCCD_L, 6, CAS-to-CAS cycles, same rank, same bank group
- TRTRS, 1, extra cycles added to TCCD_S when CAS switches rank
- AGE_LIMIT, 15, pending cycles before a rank is marked aged

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  NUM_RANKS  rank r holds a command for the bus
- req_cas  in  NUM_RANKS  1 = RD/WR (CAS), 0 = ACT/PRE/REF
- req_bg  in  NUM_RANKS*BGW  bank group of rank r's command, slice [r*BGW +: BGW]
- grant  out  NUM_RANKS  one-hot grant, combinational
- grant_valid  out  1  OR of grant
- grant_rank  out  $clog2(NUM_RANKS)  index of granted rank (0 when none)
- grant_cas  out  1  granted command is CAS
- aged_mask  out  NUM_RANKS  registered, rank age counter == AGE_LIMIT

## Operation
- Handshake: a rank holds req_valid/req_cas/req_bg stable until it sees grant[r]. The command issues in the grant cycle. The rank drops the request or presents a new one in the next cycle.
- Registered state:
  - rr_ptr (rank index)
  - elapsed (saturating, max TCCD_S+TRTRS+TCCD_L)
  - last_rank
  - last_bg
  - cas_seen
  - age[r] per rank
- CAS gap for candidate r:
  - TCCD_L if r==last_rank and bg==last_bg.
  - TCCD_S if r==last_rank and bg differs.
  - TCCD_S+TRTRS otherwise.
- Eligibility:
  - A non-CAS request is always eligible.
  - A CAS request is eligible when cas_seen==0 or elapsed ≥ gap(r).
- Block: when any aged rank has a pending but ineligible CAS, CAS requests from all non-aged ranks are ineligible. Non-CAS requests are unaffected.
- Selection:
  - If any eligible rank is aged, pick among aged eligible ranks.
  - Otherwise pick among all eligible ranks.
  - Within the chosen set, pick the first index at or after rr_ptr, wrapping modulo NUM_RANKS.
- On any grant: rr_ptr ← (granted+1) mod NUM_RANKS.
- On CAS grant: elapsed ← 1, last_rank/last_bg ← granted rank/bg, cas_seen ← 1.
- Without a CAS grant: elapsed ← min(elapsed+1, max).
- Ageing:
  - age[r] clears on grant[r] or when req_valid[r]==0.
  - Otherwise age[r] increments, saturating at AGE_LIMIT.

## Timing
- Reset values (async on rst==0):
  - grant=0, grant_valid=0, grant_rank=0, grant_cas=0, aged_mask=0
  - rr_ptr=0, elapsed=max, cas_seen=0, last_rank=0, last_bg=0, all age=0
- Grant latency is zero cycles: outputs are combinational from req_* and registered state.
- CAS at cycle t: the next CAS may issue at t+gap exactly, never earlier.
- A non-CAS grant in between CASes does not reset elapsed.
- The first CAS after reset is never spacing-blocked.
- aged_mask asserts in the cycle after age reaches AGE_LIMIT. It clears the cycle after the grant.
- All requests low: no grant. State advances (elapsed, rr_ptr unchanged).
- Single eligible request: granted regardless of rr_ptr.
- Reset mid-operation: state returns to reset values immediately. The next CAS is unconstrained.

## Test plan
- Reset: with rst=0, all requests high → grant=0, aged_mask=0. After release, first grant goes to rank 0.
- Round-robin: ranks 0–3 hold non-CAS requests continuously → grants rank 0,1,2,3,0 on consecutive cycles, grant_cas=0.
- Spacing: rank 1 CAS bg0 granted at t, then rank 1 CAS bg0 → granted t+6. Rank 1 bg1 instead → t+4. Rank 2 instead → t+5.
- Interleave: rank 0 CAS blocked at t+2 while rank 3 ACT pending → rank 3 granted at t+2, and rank 0 CAS still granted at t+6 (same bg).
- Starvation: rank 0 CAS repeatedly on alternate bg (gap 4) while rank 2 CAS waits (gap 5) → rank 2 reaches AGE_LIMIT, rank 0 CAS suppressed, rank 2 granted by elapsed==5.
- Async reset asserted one cycle after a CAS grant → outputs zero same cycle. After release, a CAS on any rank is granted immediately.
